// File: rtl/if_id_buffer.sv
// Two-entry fetch->decode instruction buffer with valid/ready on both sides.
// A flush empties it. Entries carry a misaligned-PC tag, and a saturating counter tracks entries dropped by flushes.
module if_id_buffer #(
  parameter int unsigned INSTRUCTION = 32,
  parameter int unsigned ADDRESS     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTRUCTION-1:0] in_instruction,
  input  logic [ADDRESS-1:0]     in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTRUCTION-1:0] out_instruction,
  output logic [ADDRESS-1:0]     out_pc,
  output logic [ADDRESS-1:0]     out_pc_plus4,
  output logic                   out_misaligned,
  output logic [1:0]             count,
  output logic [15:0]            flush_drops
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned DROPS_W = 16;
  localparam logic [INSTRUCTION-1:0] NOP = INSTRUCTION'(32'h0000_0013);

  typedef struct packed {
    logic [INSTRUCTION-1:0] instruction;
    logic [ADDRESS-1:0]     pc;
    logic                   misaligned;
  } entry_t;

  entry_t             entry_q [DEPTH];
  entry_t             entry_d [DEPTH];
  logic               head_q, head_d;
  logic               tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DROPS_W-1:0] flush_drops_q, flush_drops_d;

  logic               push_c;
  logic               pop_c;
  logic [DROPS_W:0]   drops_sum_c;
  entry_t             head_c;

  // Handshake flags depend on registered occupancy only.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid && in_ready && !flush;
  assign pop_c     = out_valid && out_ready && !flush;

  // Next-state: flush overrides any push/pop in the same cycle.
  always_comb begin
    entry_d       = entry_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    flush_drops_d = flush_drops_q;
    drops_sum_c   = {1'b0, flush_drops_q} + (DROPS_W+1)'(count_q);

    if (flush) begin
      head_d        = 1'b0;
      tail_d        = 1'b0;
      count_d       = '0;
      flush_drops_d = drops_sum_c[DROPS_W] ? '1 : drops_sum_c[DROPS_W-1:0];
    end else begin
      if (push_c) begin
        entry_d[tail_q] = '{instruction: in_instruction,
                            pc:          in_pc,
                            misaligned:  (in_pc[1:0] != 2'b00)};
        tail_d          = ~tail_q;
      end
      if (pop_c) begin
        head_d = ~head_q;
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      count_q       <= '0;
      flush_drops_q <= '0;
    end else begin
      entry_q       <= entry_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      flush_drops_q <= flush_drops_d;
    end
  end

  // Head view; empty buffer presents a NOP at PC 0 so decode sees harmless data.
  always_comb begin
    head_c          = entry_q[head_q];
    out_instruction = NOP;
    out_pc          = '0;
    out_pc_plus4    = '0;
    out_misaligned  = 1'b0;
    if (out_valid) begin
      out_instruction = head_c.instruction;
      out_pc          = head_c.pc;
      out_pc_plus4    = head_c.pc + ADDRESS'(4);
      out_misaligned  = head_c.misaligned;
    end
  end

  assign count       = count_q;
  assign flush_drops = flush_drops_q;

endmodule
